keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchronizer, frame-based
// debounce, and one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  // Code per key, index {row, col}; index 0 sits in the lowest nibble.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDE0F_C987_B654_A321;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

  state_t          state;
  logic [3:0]      sync1, sync2;
  logic [1:0]      row_idx;
  logic [DW-1:0]   dwell;
  logic [3:0][3:0] frame_buf;   // pressed bits, [row][col], active-high
  logic [3:0][3:0] frame_now;
  logic [3:0]      cand;
  logic [CW-1:0]   cnt, rel;

  logic            last_dwell, frame_done;
  logic [1:0]      n_hit;       // saturates at 2 = MULTI
  logic [3:0]      hit_code;
  logic            is_none, is_single;

  assign row_out    = ~(4'b0001 << row_idx);
  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign frame_done = last_dwell && (row_idx == 2'd3);

  // Frame as it will look once the current row's sample is folded in, so
  // classification on the last dwell cycle of row 3 sees all 16 keys.
  always_comb begin
    frame_now          = frame_buf;
    frame_now[row_idx] = ~sync2;
  end

  always_comb begin
    n_hit    = 2'd0;
    hit_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (frame_now[r][c]) begin
          if (n_hit != 2'd2) n_hit = n_hit + 2'd1;
          hit_code = KEY_MAP[r*4 + c];
        end
      end
    end
  end

  assign is_none   = (n_hit == 2'd0);
  assign is_single = (n_hit == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      row_idx   <= 2'd0;
      dwell     <= '0;
      frame_buf <= '0;
      state     <= S_IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      rel       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      sync1     <= col_in;
      sync2     <= sync1;
      key_valid <= 1'b0;

      if (last_dwell) begin
        dwell     <= '0;
        row_idx   <= row_idx + 2'd1;
        frame_buf <= frame_now;
      end else begin
        dwell <= dwell + DW'(1);
      end

      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (is_single) begin
              cand  <= hit_code;
              cnt   <= CW'(1);
              state <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (is_single && hit_code == cand) begin
              if (cnt >= CW'(DEBOUNCE_FRAMES - 1)) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                cnt       <= '0;
                rel       <= '0;
                state     <= S_HELD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (is_single) begin
              cand <= hit_code;
              cnt  <= CW'(1);
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_HELD: begin
            // Any key activity, even a different key, restarts the release count.
            if (is_none) begin
              if (rel >= CW'(DEBOUNCE_FRAMES - 1)) begin
                rel   <= '0;
                state <= S_IDLE;
              end else begin
                rel <= rel + CW'(1);
              end
            end else begin
              rel <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
